// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and limits for the two-port SRAM arbiter.
//   state_t : arbiter FSM states (IDLE, RD_WAIT)
//   port_t  : requester identity (PORT_A = CPU, PORT_B = loader)
//   MEM_LAT_MIN / MEM_LAT_MAX : supported SRAM read latency range
//   WAIT_CNT_W : width of the optional per-port wait counters
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;
  localparam int WAIT_CNT_W  = 16;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin decision, purely combinational.
//   req_a, req_b : requests from port A and port B
//   last         : port that won the previous grant
//   sel          : chosen port (meaningful only while valid is high)
//   valid        : at least one request is present
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last,
  output port_t sel,
  output logic  valid
);

  always_comb begin
    valid = req_a | req_b;
    if (req_a && req_b) begin
      // Tie: hand the grant to whoever did not win last time.
      sel = (last == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      sel = PORT_B;
    end else begin
      sel = PORT_A;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port SRAM between a CPU port (A) and a
// loader port (B). Writes complete in the grant cycle; a read parks the
// arbiter in RD_WAIT for MEM_LAT cycles until the read data returns.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   a_/b_req_i, we_i, addr_i, wdata_i   request side of each port
//   a_/b_gnt_o                   one-cycle grant pulse
//   a_/b_rvalid_o, rdata_o       one-cycle read return (data zero otherwise)
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i   SRAM side
//   busy_o                       high while a read is outstanding
//   a_/b_wait_cnt_o              saturating wait-cycle counters, present only
//                                when MEM_ARB_PERF_EN is defined
//
// Build option: MEM_ARB_PERF_EN adds the wait-cycle counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              a_gnt_o,
  output logic              b_gnt_o,
  output logic              a_rvalid_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef MEM_ARB_PERF_EN
  output logic [WAIT_CNT_W-1:0] a_wait_cnt_o,
  output logic [WAIT_CNT_W-1:0] b_wait_cnt_o,
`endif
  output logic              busy_o
);

  localparam int CNT_W = $clog2(MEM_LAT_MAX);

  generate
    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("mem_arbiter: MEM_LAT must be in 1..3");
    end
  endgenerate

  state_t            state;
  port_t             last_winner;
  port_t             rd_owner;
  logic [CNT_W-1:0]  lat_cnt;

  port_t             arb_sel;
  logic              arb_valid;
  logic              grant;
  logic              rd_done;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr (
    .req_a (a_req_i),
    .req_b (b_req_i),
    .last  (last_winner),
    .sel   (arb_sel),
    .valid (arb_valid)
  );

  // Grants are gated by reset_n so every output reads zero while in reset,
  // even though the request inputs may still be active.
  assign grant     = reset_n && (state == IDLE) && arb_valid;
  assign sel_we    = (arb_sel == PORT_B) ? b_we_i    : a_we_i;
  assign sel_addr  = (arb_sel == PORT_B) ? b_addr_i  : a_addr_i;
  assign sel_wdata = (arb_sel == PORT_B) ? b_wdata_i : a_wdata_i;

  // The counter starts at 0 in the first RD_WAIT cycle, so data is due
  // when it reaches MEM_LAT-1.
  assign rd_done = (state == RD_WAIT) && (lat_cnt == CNT_W'(MEM_LAT - 1));

  assign a_gnt_o     = grant && (arb_sel == PORT_A);
  assign b_gnt_o     = grant && (arb_sel == PORT_B);
  assign mem_en_o    = grant;
  assign mem_we_o    = grant && sel_we;
  assign mem_addr_o  = grant ? sel_addr  : '0;
  assign mem_wdata_o = grant ? sel_wdata : '0;

  assign a_rvalid_o = rd_done && (rd_owner == PORT_A);
  assign b_rvalid_o = rd_done && (rd_owner == PORT_B);
  assign a_rdata_o  = a_rvalid_o ? mem_rdata_i : '0;
  assign b_rdata_o  = b_rvalid_o ? mem_rdata_i : '0;
  assign busy_o     = (state == RD_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_winner <= PORT_B;
      rd_owner    <= PORT_A;
      lat_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            last_winner <= arb_sel;
            if (!sel_we) begin
              state    <= RD_WAIT;
              rd_owner <= arb_sel;
              lat_cnt  <= '0;
            end
          end
        end
        RD_WAIT: begin
          if (rd_done) begin
            state   <= IDLE;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Cycles spent requesting without being granted, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_wait_cnt_o <= '0;
      b_wait_cnt_o <= '0;
    end else begin
      if (a_req_i && !a_gnt_o && (a_wait_cnt_o != '1)) begin
        a_wait_cnt_o <= a_wait_cnt_o + 1'b1;
      end
      if (b_req_i && !b_gnt_o && (b_wait_cnt_o != '1)) begin
        b_wait_cnt_o <= b_wait_cnt_o + 1'b1;
      end
    end
  end
`else
  // Wait-cycle counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- two arbiter instances (MEM_LAT=1 and MEM_LAT=3) share
// the request inputs; each has its own SRAM model. Directed table plus
// hand-written reset/latency sequences, then randomized traffic against a
// timestamp-based reference model. Define MEM_ARB_PERF_EN to also check
// the wait counters.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;

  logic        a_gnt1, b_gnt1, a_rv1, b_rv1, en1, we1, busy1;
  logic [15:0] a_rd1, b_rd1, addr1, wd1, rdata1;
  logic        a_gnt3, b_gnt3, a_rv3, b_rv3, en3, we3, busy3;
  logic [15:0] a_rd3, b_rd3, addr3, wd3, rdata3;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] a_wc1, b_wc1, a_wc3, b_wc3;
`endif

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .a_gnt_o(a_gnt1), .b_gnt_o(b_gnt1), .a_rvalid_o(a_rv1), .b_rvalid_o(b_rv1),
    .a_rdata_o(a_rd1), .b_rdata_o(b_rd1),
    .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1),
    .mem_rdata_i(rdata1),
`ifdef MEM_ARB_PERF_EN
    .a_wait_cnt_o(a_wc1), .b_wait_cnt_o(b_wc1),
`endif
    .busy_o(busy1)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .a_gnt_o(a_gnt3), .b_gnt_o(b_gnt3), .a_rvalid_o(a_rv3), .b_rvalid_o(b_rv3),
    .a_rdata_o(a_rd3), .b_rdata_o(b_rd3),
    .mem_en_o(en3), .mem_we_o(we3), .mem_addr_o(addr3), .mem_wdata_o(wd3),
    .mem_rdata_i(rdata3),
`ifdef MEM_ARB_PERF_EN
    .a_wait_cnt_o(a_wc3), .b_wait_cnt_o(b_wc3),
`endif
    .busy_o(busy3)
  );

  // SRAM models: data appears MEM_LAT cycles after the enable cycle.
  logic [15:0] mem1 [0:65535];
  logic [15:0] mem3 [0:65535];
  logic [15:0] pipe1;
  logic [15:0] pipe3 [0:2];
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      mem1[pre_addr] <= pre_data;
      mem3[pre_addr] <= pre_data;
    end
    if (en1 && we1) mem1[addr1] <= wd1;
    pipe1 <= (en1 && !we1) ? mem1[addr1] : 16'hDEAD;
    if (en3 && we3) mem3[addr3] <= wd3;
    pipe3[0] <= (en3 && !we3) ? mem3[addr3] : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata1 = pipe1;
  assign rdata3 = pipe3[2];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] addr, input logic [15:0] data);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    next_cycle();
    pre_we = 1'b0;
  endtask

  task automatic check_all_zero3(input string tag);
    chk1({tag, " a_gnt3"}, a_gnt3, 1'b0);
    chk1({tag, " b_gnt3"}, b_gnt3, 1'b0);
    chk1({tag, " a_rv3"}, a_rv3, 1'b0);
    chk1({tag, " b_rv3"}, b_rv3, 1'b0);
    chk1({tag, " en3"}, en3, 1'b0);
    chk1({tag, " we3"}, we3, 1'b0);
    chk1({tag, " busy3"}, busy3, 1'b0);
    chk16({tag, " addr3"}, addr3, 16'h0);
    chk16({tag, " a_rd3"}, a_rd3, 16'h0);
  endtask

  typedef struct {
    logic ar, aw, br, bw;
    logic [15:0] aa, ad, ba, bd;
    logic ag, bg, arv, brv, en, we, busy;
    logic [15:0] addr, wd, ard, brd;
  } vec_t;

  // ctl = {a_req, a_we, b_req, b_we}; fl = {a_gnt, b_gnt, a_rv, b_rv, en, we, busy}
  function automatic vec_t mk(input logic [3:0] ctl, input logic [15:0] aa, input logic [15:0] ad,
                              input logic [15:0] ba, input logic [15:0] bd, input logic [6:0] fl,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input logic [15:0] ard, input logic [15:0] brd);
    vec_t v;
    v.ar = ctl[3]; v.aw = ctl[2]; v.br = ctl[1]; v.bw = ctl[0];
    v.aa = aa; v.ad = ad; v.ba = ba; v.bd = bd;
    v.ag = fl[6]; v.bg = fl[5]; v.arv = fl[4]; v.brv = fl[3];
    v.en = fl[2]; v.we = fl[1]; v.busy = fl[0];
    v.addr = addr; v.wd = wd; v.ard = ard; v.brd = brd;
    return v;
  endfunction

  typedef struct {
    int          due;
    bit          port_b;
    logic [15:0] data;
  } rd_t;

  vec_t        tbl [17];
  rd_t         pq [$];
  logic [15:0] ref_mem [0:15];

  initial begin
    // Directed table for the MEM_LAT=1 instance, starting right after reset.
    tbl[0]  = mk(4'b1010, 16'h3000, 16'h0000, 16'h3001, 16'h0000, 7'b1000100, 16'h3000, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(4'b0010, 16'h0000, 16'h0000, 16'h3001, 16'h0000, 7'b0010001, 16'h0000, 16'h0000, 16'h1234, 16'h0000);
    tbl[2]  = mk(4'b0010, 16'h0000, 16'h0000, 16'h3001, 16'h0000, 7'b0100100, 16'h3001, 16'h0000, 16'h0000, 16'h0000);
    tbl[3]  = mk(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0001001, 16'h0000, 16'h0000, 16'h0000, 16'h5678);
    tbl[4]  = mk(4'b1000, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 7'b1000100, 16'h3000, 16'h0000, 16'h0000, 16'h0000);
    tbl[5]  = mk(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0010001, 16'h0000, 16'h0000, 16'h1234, 16'h0000);
    tbl[6]  = mk(4'b0011, 16'h0000, 16'h0000, 16'h0000, 16'h00A0, 7'b0100110, 16'h0000, 16'h00A0, 16'h0000, 16'h0000);
    tbl[7]  = mk(4'b0011, 16'h0000, 16'h0000, 16'h0001, 16'h00A1, 7'b0100110, 16'h0001, 16'h00A1, 16'h0000, 16'h0000);
    tbl[8]  = mk(4'b0011, 16'h0000, 16'h0000, 16'h0002, 16'h00A2, 7'b0100110, 16'h0002, 16'h00A2, 16'h0000, 16'h0000);
    tbl[9]  = mk(4'b0011, 16'h0000, 16'h0000, 16'h0003, 16'h00A3, 7'b0100110, 16'h0003, 16'h00A3, 16'h0000, 16'h0000);
    tbl[10] = mk(4'b1110, 16'h0005, 16'h0055, 16'h0002, 16'h0000, 7'b1000110, 16'h0005, 16'h0055, 16'h0000, 16'h0000);
    tbl[11] = mk(4'b0010, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 7'b0100100, 16'h0002, 16'h0000, 16'h0000, 16'h0000);
    tbl[12] = mk(4'b1100, 16'h0006, 16'h0066, 16'h0000, 16'h0000, 7'b0001001, 16'h0000, 16'h0000, 16'h0000, 16'h00A2);
    tbl[13] = mk(4'b1100, 16'h0006, 16'h0066, 16'h0000, 16'h0000, 7'b1000110, 16'h0006, 16'h0066, 16'h0000, 16'h0000);
    tbl[14] = mk(4'b1111, 16'h0007, 16'h0077, 16'h0008, 16'h0088, 7'b0100110, 16'h0008, 16'h0088, 16'h0000, 16'h0000);
    tbl[15] = mk(4'b1100, 16'h0007, 16'h0077, 16'h0000, 16'h0000, 7'b1000110, 16'h0007, 16'h0077, 16'h0000, 16'h0000);
    tbl[16] = mk(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    pre_we = 1'b0; pre_addr = 16'h0; pre_data = 16'h0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    next_cycle();
    preload(16'h3000, 16'h1234);
    preload(16'h3001, 16'h5678);

    // Outputs must stay quiet in reset even with both ports requesting.
    drive(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3333, 16'h0);
    @(negedge clk);
    chk1("rst a_gnt1", a_gnt1, 1'b0);
    chk1("rst b_gnt1", b_gnt1, 1'b0);
    chk1("rst en1", en1, 1'b0);
    chk1("rst we1", we1, 1'b0);
    chk16("rst addr1", addr1, 16'h0);
    chk16("rst wd1", wd1, 16'h0);
    chk1("rst a_rv1", a_rv1, 1'b0);
    chk1("rst b_rv1", b_rv1, 1'b0);
    chk1("rst busy1", busy1, 1'b0);
    check_all_zero3("rst");
`ifdef MEM_ARB_PERF_EN
    chk16("rst a_wc3", a_wc3, 16'h0);
    chk16("rst b_wc3", b_wc3, 16'h0);
`endif
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      next_cycle();
      drive(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd);
      @(negedge clk);
      chk1($sformatf("t%0d a_gnt", i), a_gnt1, tbl[i].ag);
      chk1($sformatf("t%0d b_gnt", i), b_gnt1, tbl[i].bg);
      chk1($sformatf("t%0d a_rvalid", i), a_rv1, tbl[i].arv);
      chk1($sformatf("t%0d b_rvalid", i), b_rv1, tbl[i].brv);
      chk1($sformatf("t%0d mem_en", i), en1, tbl[i].en);
      chk1($sformatf("t%0d mem_we", i), we1, tbl[i].we);
      chk1($sformatf("t%0d busy", i), busy1, tbl[i].busy);
      if (tbl[i].en) chk16($sformatf("t%0d mem_addr", i), addr1, tbl[i].addr);
      if (tbl[i].we) chk16($sformatf("t%0d mem_wdata", i), wd1, tbl[i].wd);
      if (tbl[i].arv) chk16($sformatf("t%0d a_rdata", i), a_rd1, tbl[i].ard);
      if (tbl[i].brv) chk16($sformatf("t%0d b_rdata", i), b_rd1, tbl[i].brd);
    end
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) chk16($sformatf("sram[%0d]", i), mem1[i], 16'h00A0 + 16'(i));
    chk16("sram[5]", mem1[5], 16'h0055);
    chk16("sram[6]", mem1[6], 16'h0066);
    chk16("sram[7]", mem1[7], 16'h0077);
    chk16("sram[8]", mem1[8], 16'h0088);

    // MEM_LAT=3: reset one cycle after a read grant discards the read.
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    drive(1'b1, 1'b0, 16'h3000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1("abort a_gnt3", a_gnt3, 1'b1);
    next_cycle();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check_all_zero3("abort");
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk);
      chk1($sformatf("abort post%0d a_rv3", i), a_rv3, 1'b0);
      chk1($sformatf("abort post%0d busy3", i), busy3, 1'b0);
    end

    // MEM_LAT=3: A read in flight while B waits exactly three cycles.
    next_cycle();
    drive(1'b1, 1'b0, 16'h3000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1("lat3 a_gnt3", a_gnt3, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h3001, 16'h0);
      @(negedge clk);
      chk1($sformatf("lat3 c%0d busy3", k), busy3, 1'b1);
      chk1($sformatf("lat3 c%0d b_gnt3", k), b_gnt3, 1'b0);
      chk1($sformatf("lat3 c%0d en3", k), en3, 1'b0);
      chk1($sformatf("lat3 c%0d a_rv3", k), a_rv3, (k == 3));
    end
    chk16("lat3 a_rd3", a_rd3, 16'h1234);
    next_cycle();
    @(negedge clk);
    chk1("lat3 b_gnt3", b_gnt3, 1'b1);
`ifdef MEM_ARB_PERF_EN
    chk16("perf b_wc3", b_wc3, 16'd3);
    chk16("perf a_wc3", a_wc3, 16'd0);
`endif
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1("lat3 b busy3", busy3, 1'b1);

    // Randomized traffic on the MEM_LAT=3 instance against a timestamp model.
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      ref_mem[i] = v;
      preload(16'(i), v);
    end
    reset_n = 1'b1;
    begin
      int   cyc, free_at;
      bit   last_b, a_hold, b_hold, win_b;
      logic ea_g, eb_g, ea_v, eb_v, e_en, e_we, e_busy;
      logic [15:0] e_addr, e_wd, e_rd;
      int   awc, bwc;
      cyc = 0; free_at = 0; last_b = 1'b1; a_hold = 1'b0; b_hold = 1'b0;
      awc = 0; bwc = 0;
      pq.delete();
      for (int n = 0; n < 400; n++) begin
        next_cycle();
        if (a_hold) begin
          if ($urandom_range(7) == 0) a_hold = 1'b0;
        end else if ($urandom_range(2) != 0) begin
          a_hold = 1'b1; a_we = 1'($urandom_range(1));
          a_addr = 16'($urandom_range(15)); a_wdata = 16'($urandom);
        end
        if (b_hold) begin
          if ($urandom_range(7) == 0) b_hold = 1'b0;
        end else if ($urandom_range(2) != 0) begin
          b_hold = 1'b1; b_we = 1'($urandom_range(1));
          b_addr = 16'($urandom_range(15)); b_wdata = 16'($urandom);
        end
        a_req = a_hold;
        b_req = b_hold;
        @(negedge clk);
        ea_g = 1'b0; eb_g = 1'b0; ea_v = 1'b0; eb_v = 1'b0;
        e_en = 1'b0; e_we = 1'b0; e_addr = 16'h0; e_wd = 16'h0; e_rd = 16'h0;
        e_busy = (cyc < free_at);
        if (pq.size() > 0 && pq[0].due == cyc) begin
          if (pq[0].port_b) eb_v = 1'b1; else ea_v = 1'b1;
          e_rd = pq[0].data;
          void'(pq.pop_front());
        end
        if (cyc >= free_at && (a_req || b_req)) begin
          win_b  = b_req && (!a_req || !last_b);
          ea_g   = !win_b; eb_g = win_b;
          e_en   = 1'b1;
          e_we   = win_b ? b_we : a_we;
          e_addr = win_b ? b_addr : a_addr;
          e_wd   = win_b ? b_wdata : a_wdata;
          if (e_we) ref_mem[e_addr[3:0]] = e_wd;
          else begin
            pq.push_back('{due: cyc + 3, port_b: win_b, data: ref_mem[e_addr[3:0]]});
            free_at = cyc + 4;
          end
          last_b = win_b;
        end
        chk1($sformatf("r%0d a_gnt", n), a_gnt3, ea_g);
        chk1($sformatf("r%0d b_gnt", n), b_gnt3, eb_g);
        chk1($sformatf("r%0d a_rvalid", n), a_rv3, ea_v);
        chk1($sformatf("r%0d b_rvalid", n), b_rv3, eb_v);
        chk1($sformatf("r%0d mem_en", n), en3, e_en);
        chk1($sformatf("r%0d mem_we", n), we3, e_we);
        chk1($sformatf("r%0d busy", n), busy3, e_busy);
        if (e_en) chk16($sformatf("r%0d mem_addr", n), addr3, e_addr);
        if (e_we) chk16($sformatf("r%0d mem_wdata", n), wd3, e_wd);
        if (ea_v) chk16($sformatf("r%0d a_rdata", n), a_rd3, e_rd);
        if (eb_v) chk16($sformatf("r%0d b_rdata", n), b_rd3, e_rd);
`ifdef MEM_ARB_PERF_EN
        chk16($sformatf("r%0d a_wait", n), a_wc3, 16'(awc));
        chk16($sformatf("r%0d b_wait", n), b_wc3, 16'(bwc));
        if (a_req && !ea_g) awc++;
        if (b_req && !eb_g) bwc++;
`endif
        if (ea_g) a_hold = 1'b0;
        if (eb_g) b_hold = 1'b0;
        cyc++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width.
REQ-002 Parameter DATA_W, default 16, data width.
REQ-003 Parameter MEM_LAT, default 1, SRAM read latency in cycles; legal range 1..3.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 a_req_i / b_req_i  input  1  access request, port A (CPU) / port B (loader).
REQ-007 a_we_i / b_we_i  input  1  1 = write, 0 = read.
REQ-008 a_addr_i / b_addr_i  input  ADDR_W  access address.
REQ-009 a_wdata_i / b_wdata_i  input  DATA_W  write data.
REQ-010 a_gnt_o / b_gnt_o  output  1  one-cycle grant pulse.
REQ-011 a_rvalid_o / b_rvalid_o  output  1  one-cycle read-data-valid pulse.
REQ-012 a_rdata_o / b_rdata_o  output  DATA_W  read data, meaningful only while rvalid is high.
REQ-013 mem_en_o, mem_we_o  output  1  SRAM enable and write strobe.
REQ-014 mem_addr_o  output  ADDR_W  SRAM address.
REQ-015 mem_wdata_o  output  DATA_W  SRAM write data.
REQ-016 mem_rdata_i  input  DATA_W  SRAM read data.
REQ-017 busy_o  output  1  high while a read is outstanding.

Function
REQ-018 The FSM SHALL have states IDLE and RD_WAIT.
REQ-019 In IDLE with any req high, the arbiter SHALL assert exactly one gnt in that cycle.
REQ-020 In the grant cycle, mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be driven combinationally from the winner's inputs.
REQ-021 A requester SHALL hold we, addr and wdata stable from req assertion until its gnt.
REQ-022 A granted write SHALL complete in the grant cycle; the FSM stays in IDLE, and a new grant is permitted on the next cycle.
REQ-023 A granted read SHALL move the FSM to RD_WAIT.
REQ-024 The winner's rvalid SHALL pulse exactly MEM_LAT cycles after gnt, with rdata equal to mem_rdata_i in that cycle.
REQ-025 The FSM SHALL return to IDLE in the same cycle as that rvalid pulse.
REQ-026 In RD_WAIT no gnt SHALL be issued and mem_en_o SHALL be 0.
REQ-027 With both req high in IDLE, the grant SHALL go to the port that was not the last winner (two-way round robin).
REQ-028 last_winner SHALL update on every grant.
REQ-029 With a single requester, that port SHALL win regardless of last_winner.
REQ-030 A req that is held high after its gnt SHALL be treated as a new access.
REQ-031 A req that drops before gnt SHALL be ignored; no state change results.
REQ-032 rvalid of one port and gnt of the other port SHALL never coincide with the FSM in RD_WAIT.
REQ-033 MEM_LAT outside 1..3 SHALL be rejected at elaboration.

Reset
REQ-034 While reset_n is low, all outputs SHALL be 0, the FSM SHALL be IDLE, the latency counter 0 and last_winner = B (so port A wins the first tie).
REQ-035 A reset asserted in RD_WAIT SHALL discard the outstanding read; no rvalid pulse follows after release.

Configuration
REQ-036 With MEM_ARB_PERF_EN defined, ports a_wait_cnt_o and b_wait_cnt_o (output, 16 bits) SHALL exist; each counts cycles in which that port's req is high and its gnt is low, saturating at 0xFFFF and cleared by reset.
REQ-037 Without MEM_ARB_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the state enum (IDLE, RD_WAIT), the port-select enum (PORT_A, PORT_B) and the MEM_LAT limit constants.
REQ-039 The round-robin decision SHALL live in sub-module rr_arb2 (inputs req_a, req_b, last; outputs sel and valid); the FSM and the latency counter stay in mem_arbiter.

Verification
REQ-040 Port A read, addr 0x3000, SRAM holds 0x1234, MEM_LAT=1 -> a_gnt_o in cycle N, a_rvalid_o with a_rdata_o=0x1234 in N+1, busy_o high for 1 cycle.
REQ-041 Both ports request reads immediately after reset -> A granted first, then B granted in A's rvalid cycle +1; B's rvalid MEM_LAT cycles after its grant.
REQ-042 Port B issues 4 back-to-back writes (0x0000..0x0003, data 0xA0..0xA3) -> gnt every cycle, mem_we_o high for 4 consecutive cycles, SRAM contents verified.
REQ-043 MEM_LAT=3, port A read granted, reset_n pulled low 1 cycle later -> all outputs 0 and no a_rvalid_o afterwards.
REQ-044 MEM_ARB_PERF_EN defined, A holds a read in RD_WAIT while B waits 3 cycles -> b_wait_cnt_o = 3.
